// File: rtl/data_memory_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_memory_responder : 32-bit word memory answering a data-memory controller
//                         with a fixed-latency ack, byte-lane writes, registered read data
// Revision 1.0
// ----------------------------------------------------------------------------
module data_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Address,
  input  logic [31:0] MWriteData,
  input  logic [3:0]  ByteEnable,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  output logic [31:0] MReadData,
  output logic        DataMem_Ack,
  output logic        Busy
);
  localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_ACK  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic                  r_rd;
  logic                  r_wr;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [0:c_DEPTH-1];

  logic                  w_accept;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [3:0]            w_sel_be;
  logic                  w_sel_rd;
  logic                  w_sel_wr;
  logic                  w_unused_addr;

  assign w_unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
  assign w_accept      = (r_state == c_IDLE) && (ReadEnable || WriteEnable);

  // With LATENCY=1 the commit happens on the accepting edge, so use the live inputs there
  assign w_sel_addr  = (r_state == c_IDLE) ? Address[ADDR_WIDTH+1:2] : r_addr;
  assign w_sel_wdata = (r_state == c_IDLE) ? MWriteData  : r_wdata;
  assign w_sel_be    = (r_state == c_IDLE) ? ByteEnable  : r_be;
  assign w_sel_rd    = (r_state == c_IDLE) ? ReadEnable  : r_rd;
  assign w_sel_wr    = (r_state == c_IDLE) ? WriteEnable : r_wr;
  assign w_commit    = !RST && (r_state != c_ACK) && (w_next == c_ACK);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      c_IDLE:  if (w_accept) w_next = (LATENCY == 1) ? c_ACK : c_WAIT;
      c_WAIT:  if (r_cnt <= 4'd1) w_next = c_ACK;
      c_ACK:   w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    DataMem_Ack = (r_state == c_ACK);
    Busy        = (r_state != c_IDLE);
    MReadData   = r_rdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= c_CNT_LOAD;
      r_addr  <= Address[ADDR_WIDTH+1:2];
      r_wdata <= MWriteData;
      r_be    <= ByteEnable;
      r_rd    <= ReadEnable;
      r_wr    <= WriteEnable;
    end else if (r_state == c_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Array has no reset so its contents survive RST
  always_ff @(posedge CLK) begin
    if (w_commit && w_sel_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_sel_be[b]) r_mem[w_sel_addr][8*b +: 8] <= w_sel_wdata[8*b +: 8];
      end
    end
  end

  // Reads sample the pre-write word, which gives read-before-write on a combined request
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rdata <= 32'h0;
    end else if (w_commit && w_sel_rd) begin
      r_rdata <= r_mem[w_sel_addr];
    end
  end
endmodule
`default_nettype wire
